// File: rtl/pushbutton_debouncer_multi.sv
// N-channel push-button debouncer: 2-FF sync, integrating debounce,
// press/release pulses, long-press hold detection and auto-repeat.
module pushbutton_debouncer_multi #(
  parameter int NUM_CH        = 4,
  parameter int CNT_WIDTH     = 5,
  parameter int ACTIVE_LOW    = 1,
  parameter int HOLD_W        = 20,
  parameter int HOLD_CYCLES   = 1000000,
  parameter int REPEAT_CYCLES = 250000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] pb,
  output logic [NUM_CH-1:0] pb_state,
  output logic [NUM_CH-1:0] pb_down,
  output logic [NUM_CH-1:0] pb_up,
  output logic [NUM_CH-1:0] pb_hold,
  output logic [NUM_CH-1:0] pb_repeat
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESSED,
    S_HELD
  } hold_st_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [HOLD_W-1:0]    HCNT_MAX = '1;
  localparam logic [HOLD_W-1:0]    HOLD_T   = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0]    REP_T    = HOLD_W'(REPEAT_CYCLES);
  localparam bit                   REP_EN   = (REPEAT_CYCLES != 0);

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("NUM_CH must be >= 1");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt_w
    $error("CNT_WIDTH must be >= 1");
  end
  if (HOLD_W < 1 || HOLD_W > 31) begin : g_bad_hold_w
    $error("HOLD_W must be in 1..31");
  end
  if (HOLD_CYCLES < 1 ||
      longint'(HOLD_CYCLES) >= (longint'(1) << HOLD_W))
  begin : g_bad_hold
    $error("HOLD_CYCLES out of range 1..2**HOLD_W-1");
  end
  if (REPEAT_CYCLES < 0 ||
      longint'(REPEAT_CYCLES) >= (longint'(1) << HOLD_W))
  begin : g_bad_rep
    $error("REPEAT_CYCLES out of range 0..2**HOLD_W-1");
  end

  logic [NUM_CH-1:0] pb_n;

  // Pressed is always 1 from here on, whatever the board polarity.
  assign pb_n = (ACTIVE_LOW != 0) ? ~pb : pb;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch

    logic                 s0_q;
    logic                 s1_q;
    logic                 state_q;
    logic                 state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 down_q;
    logic                 down_d;
    logic                 up_q;
    logic                 up_d;
    hold_st_e             fsm_q;
    hold_st_e             fsm_d;
    logic [HOLD_W-1:0]    hcnt_q;
    logic [HOLD_W-1:0]    hcnt_d;
    logic [HOLD_W-1:0]    hinc;
    logic                 hold_q;
    logic                 hold_d;
    logic                 rep_q;
    logic                 rep_d;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      down_d  = 1'b0;
      up_d    = 1'b0;
      if (s1_q == state_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        state_d = ~state_q;
        cnt_d   = '0;
        down_d  = ~state_q;
        up_d    = state_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    assign hinc = (hcnt_q == HCNT_MAX) ? hcnt_q
                                       : hcnt_q + 1'b1;

    always_comb begin
      fsm_d  = fsm_q;
      hcnt_d = hcnt_q;
      hold_d = 1'b0;
      rep_d  = 1'b0;
      // A release on the same edge as a hold/repeat suppresses it.
      if (up_d) begin
        fsm_d  = S_IDLE;
        hcnt_d = '0;
      end else begin
        unique case (fsm_q)
          S_IDLE: begin
            if (down_d) begin
              fsm_d  = S_PRESSED;
              hcnt_d = '0;
            end
          end
          S_PRESSED: begin
            if (hinc == HOLD_T) begin
              hold_d = 1'b1;
              hcnt_d = '0;
              fsm_d  = S_HELD;
            end else begin
              hcnt_d = hinc;
            end
          end
          S_HELD: begin
            if (REP_EN) begin
              if (hinc == REP_T) begin
                rep_d  = 1'b1;
                hcnt_d = '0;
              end else begin
                hcnt_d = hinc;
              end
            end
          end
          default: begin
            fsm_d  = S_IDLE;
            hcnt_d = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s0_q    <= 1'b0;
        s1_q    <= 1'b0;
        state_q <= 1'b0;
        cnt_q   <= '0;
        down_q  <= 1'b0;
        up_q    <= 1'b0;
        fsm_q   <= S_IDLE;
        hcnt_q  <= '0;
        hold_q  <= 1'b0;
        rep_q   <= 1'b0;
      end else begin
        s0_q    <= pb_n[g];
        s1_q    <= s0_q;
        state_q <= state_d;
        cnt_q   <= cnt_d;
        down_q  <= down_d;
        up_q    <= up_d;
        fsm_q   <= fsm_d;
        hcnt_q  <= hcnt_d;
        hold_q  <= hold_d;
        rep_q   <= rep_d;
      end
    end

    assign pb_state[g]  = state_q;
    assign pb_down[g]   = down_q;
    assign pb_up[g]     = up_q;
    assign pb_hold[g]   = hold_q;
    assign pb_repeat[g] = rep_q;
  end

endmodule

// File: tb/tb_pushbutton_debouncer_multi.sv
// Directed + randomized bench for pushbutton_debouncer_multi,
// checked against an event-time reference model.
module tb_pushbutton_debouncer_multi;

  localparam int NCH  = 2;
  localparam int CW   = 3;
  localparam int WIN  = 1 << CW;
  localparam int HOLD = 20;
  localparam int REP  = 5;

  logic           clk;
  logic           rst;
  logic [NCH-1:0] pb;
  logic [NCH-1:0] pb_state;
  logic [NCH-1:0] pb_down;
  logic [NCH-1:0] pb_up;
  logic [NCH-1:0] pb_hold;
  logic [NCH-1:0] pb_repeat;

  pushbutton_debouncer_multi #(
    .NUM_CH       (NCH),
    .CNT_WIDTH    (CW),
    .ACTIVE_LOW   (1),
    .HOLD_W       (20),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pb       (pb),
    .pb_state (pb_state),
    .pb_down  (pb_down),
    .pb_up    (pb_up),
    .pb_hold  (pb_hold),
    .pb_repeat(pb_repeat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors;
  int unsigned miscompares;

  // Reference model: sync delay line, mismatch run length,
  // and the edge number at which each channel was pressed.
  logic [NCH-1:0] m_s0, m_s1, m_state;
  logic [NCH-1:0] e_down, e_up, e_hold, e_rep;
  int             m_run [NCH];
  longint         m_press [NCH];
  longint         tnow;
  logic [NCH-1:0] pb_cur;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s t=%0d got=%0h exp=%0h",
             tag, tnow, obs, exp);
    end
  endtask

  task automatic model_step(input logic r,
                            input logic [NCH-1:0] p);
    longint el;
    tnow++;
    e_down = '0;
    e_up   = '0;
    e_hold = '0;
    e_rep  = '0;
    if (r) begin
      m_s0    = '0;
      m_s1    = '0;
      m_state = '0;
      for (int c = 0; c < NCH; c++) m_run[c] = 0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (m_s1[c] != m_state[c]) begin
          m_run[c]++;
          if (m_run[c] == WIN) begin
            m_state[c] = ~m_state[c];
            m_run[c]   = 0;
            if (m_state[c]) begin
              e_down[c]  = 1'b1;
              m_press[c] = tnow;
            end else begin
              e_up[c] = 1'b1;
            end
          end
        end else begin
          m_run[c] = 0;
        end
        if (m_state[c] && !e_down[c]) begin
          el = tnow - m_press[c];
          if (el == HOLD)
            e_hold[c] = 1'b1;
          else if (el > HOLD && ((el - HOLD) % REP) == 0)
            e_rep[c] = 1'b1;
        end
      end
      m_s1 = m_s0;
      m_s0 = ~p;
    end
  endtask

  task automatic tick(input logic r, input logic [NCH-1:0] p);
    rst = r;
    pb  = p;
    @(posedge clk);
    model_step(r, p);
    #1;
    chk("pb_state",  32'(pb_state),  32'(m_state));
    chk("pb_down",   32'(pb_down),   32'(e_down));
    chk("pb_up",     32'(pb_up),     32'(e_up));
    chk("pb_hold",   32'(pb_hold),   32'(e_hold));
    chk("pb_repeat", 32'(pb_repeat), 32'(e_rep));
  endtask

  function automatic logic sel_bit(input int sel, input int ch);
    case (sel)
      0:       return pb_down[ch];
      1:       return pb_up[ch];
      2:       return pb_hold[ch];
      default: return pb_repeat[ch];
    endcase
  endfunction

  task automatic wait_sig(input int sel, input int ch,
                          input int limit, output int n);
    bit hit;
    hit = 1'b0;
    n   = 0;
    while (!hit && n < limit) begin
      tick(1'b0, pb_cur);
      n++;
      hit = sel_bit(sel, ch);
    end
    vectors++;
    assert (hit) else begin
      miscompares++;
      $error("FAIL timeout sel=%0d ch=%0d got=0 exp=1", sel, ch);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, pb_cur);
  endtask

  int             n;
  int             downs;
  int             t_down, t_hold, t_rep, reps;
  int             rem [NCH];
  logic [NCH-1:0] lvl;
  logic [NCH-1:0] p;

  initial begin
    vectors     = 0;
    miscompares = 0;
    tnow        = 0;
    m_s0        = '0;
    m_s1        = '0;
    m_state     = '0;
    for (int c = 0; c < NCH; c++) begin
      m_run[c]   = 0;
      m_press[c] = 0;
    end
    pb_cur = 2'b11;
    rst    = 1'b1;
    pb     = pb_cur;

    // 1: reset with buttons released, then idle
    tick(1'b1, pb_cur);
    tick(1'b1, pb_cur);
    chk("rst_state", 32'(pb_state), 32'd0);
    idle(50);
    chk("idle_state", 32'(pb_state), 32'd0);

    // 2: clean press on ch0, 10 edges to pb_down
    pb_cur = 2'b10;
    wait_sig(0, 0, 40, n);
    chk("lat_press", 32'(n), 32'd10);
    chk("ch1_quiet", 32'(pb_state[1]), 32'd0);
    pb_cur = 2'b11;
    wait_sig(1, 0, 40, n);
    chk("lat_release", 32'(n), 32'd10);
    idle(10);

    // 3: bounce low 6, high 1, then steady low
    downs = 0;
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, (i < 6) ? 2'b10 : 2'b11);
      if (pb_down[0]) downs++;
    end
    pb_cur = 2'b10;
    wait_sig(0, 0, 40, n);
    chk("bounce_lat", 32'(n), 32'd10);
    chk("bounce_early_down", 32'(downs), 32'd0);
    pb_cur = 2'b11;
    wait_sig(1, 0, 60, n);
    idle(10);

    // 4: long press on ch1 -> hold then repeats
    pb_cur = 2'b01;
    t_down = -1;
    t_hold = -1;
    t_rep  = -1;
    reps   = 0;
    for (int i = 1; i <= 60; i++) begin
      tick(1'b0, pb_cur);
      if (pb_down[1]) t_down = i;
      if (pb_hold[1]) t_hold = i;
      if (pb_repeat[1]) begin
        if (t_rep < 0) t_rep = i;
        reps++;
      end
    end
    chk("down_t", 32'(t_down), 32'd10);
    chk("hold_gap", 32'(t_hold - t_down), 32'd20);
    chk("rep_gap", 32'(t_rep - t_hold), 32'd5);
    chk("rep_cnt", 32'(reps), 32'd6);
    pb_cur = 2'b11;
    wait_sig(1, 1, 40, n);
    reps = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, pb_cur);
      if (pb_repeat[1] || pb_up[1]) reps++;
    end
    chk("after_release", 32'(reps), 32'd0);

    // 5: reset mid-hold with ch0 still pressed
    pb_cur = 2'b10;
    wait_sig(0, 0, 40, n);
    idle(15);
    tick(1'b1, pb_cur);
    chk("rst_mid_state", 32'(pb_state), 32'd0);
    chk("rst_mid_up", 32'(pb_up), 32'd0);
    wait_sig(0, 0, 40, n);
    chk("redetect_lat", 32'(n), 32'd10);
    pb_cur = 2'b11;
    wait_sig(1, 0, 60, n);
    idle(10);

    // 6: both channels pressed together
    pb_cur = 2'b00;
    wait_sig(0, 0, 40, n);
    chk("both_down", 32'(pb_down), 32'd3);
    pb_cur = 2'b11;
    wait_sig(1, 0, 60, n);
    idle(10);

    // Randomized: glitchy levels of random length, rare resets
    lvl = 2'b11;
    for (int c = 0; c < NCH; c++) rem[c] = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < NCH; c++) begin
        if (rem[c] == 0) begin
          lvl[c] = ~lvl[c];
          rem[c] = int'($urandom_range(60, 1));
        end else begin
          rem[c]--;
        end
      end
      p = lvl;
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(11, 0) == 0) p[c] = ~p[c];
      tick(($urandom_range(499, 0) == 0), p);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
